infix_to_postfix: RTL and testbench

- Shunting-yard converter and transmit side of the evaluator token interface.
- Accepts infix tokens (8-bit numbers; operators + - * /; parentheses) one per handshake.
- Emits the postfix token stream as single-cycle NUMBER_STB / SIGN_STB pulses. These feed the RPN evaluator's INPUT_NUMBER / INPUT_SIGN ports.
- Ends each expression with the combined terminator strobe the evaluator decodes as "finished".

---
 rtl/infix_to_postfix.sv | 274 +++++++++++++++++++++++++++
 tb/tb_infix_to_postfix.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/infix_to_postfix.sv
// infix_to_postfix
// Shunting-yard converter: takes infix tokens one per handshake and emits the
// postfix stream as single-cycle strobes for an RPN evaluator. Each expression
// ends with a combined NUMBER_STB+SIGN_STB terminator carrying "=".
//
// Ports:
//   CLK, RST                 clock, asynchronous active-low reset
//   IN_TOKEN/IN_IS_OP/IN_END token value, operator flag, end-of-expression
//   IN_VALID/IN_READY        input handshake
//   DST_BUSY                 evaluator busy, blocks strobes
//   OUT_NUMBER/NUMBER_STB    number output and strobe
//   OUT_SIGN/SIGN_STB        operator output and strobe
//   DONE                     terminator pulse
//   ERR                      sticky error, cleared only by reset
//   OUT_COUNT                strobe counter (only with TOKEN_CNT_EN defined)
//
// Optional feature macro: TOKEN_CNT_EN
module infix_to_postfix #(
  parameter int DEPTH   = 8,
  parameter int MIN_GAP = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] IN_TOKEN,
  input  logic       IN_IS_OP,
  input  logic       IN_END,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic       DST_BUSY,
  output logic [7:0] OUT_NUMBER,
  output logic       NUMBER_STB,
  output logic [7:0] OUT_SIGN,
  output logic       SIGN_STB,
  output logic       DONE,
`ifdef TOKEN_CNT_EN
  output logic [7:0] OUT_COUNT,
`endif
  output logic       ERR
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SPW = AW + 1;

  localparam logic [7:0] C_LPAR = 8'h28;
  localparam logic [7:0] C_RPAR = 8'h29;
  localparam logic [7:0] C_MUL  = 8'h2A;
  localparam logic [7:0] C_ADD  = 8'h2B;
  localparam logic [7:0] C_SUB  = 8'h2D;
  localparam logic [7:0] C_DIV  = 8'h2F;
  localparam logic [7:0] C_EQ   = 8'h3D;

  typedef enum logic [2:0] {
    S_IDLE, S_EMIT_NUM, S_POP_PREC, S_POP_PAREN, S_DRAIN, S_TERM, S_ERROR
  } state_t;

  // "(" maps to 0 so an incoming operator never pops past it.
  function automatic logic [1:0] prec(input logic [7:0] tok);
    case (tok)
      C_MUL, C_DIV: prec = 2'd2;
      C_ADD, C_SUB: prec = 2'd1;
      default:      prec = 2'd0;
    endcase
  endfunction

  state_t         r_state;
  logic [7:0]     r_stack [DEPTH];
  logic [SPW-1:0] r_sp;
  logic [7:0]     r_op;
  logic [7:0]     r_num;
  logic [7:0]     r_gap;
  logic           r_ready;
  logic [7:0]     r_out_number;
  logic [7:0]     r_out_sign;
  logic           r_number_stb;
  logic           r_sign_stb;
  logic           r_done;
  logic           r_err;

  logic [AW-1:0]  w_top_idx;
  logic [7:0]     w_top;
  logic           w_empty;
  logic           w_full;
  logic           w_accept;
  logic           w_can_fire;
  logic           w_prec_pop;
  logic           w_push;
  logic [7:0]     w_push_val;

  assign w_top_idx  = r_sp[AW-1:0] - 1'b1;
  assign w_top      = r_stack[w_top_idx];
  assign w_empty    = (r_sp == '0);
  assign w_full     = (r_sp == SPW'(DEPTH));
  assign w_accept   = IN_VALID && r_ready && (r_state == S_IDLE);
  // r_gap counts consecutive strobe-free cycles, saturating.
  assign w_can_fire = !DST_BUSY && (r_gap >= 8'(MIN_GAP));
  assign w_prec_pop = !w_empty && (prec(w_top) >= prec(r_op));

  assign w_push = (w_accept && !IN_END && IN_IS_OP && (IN_TOKEN == C_LPAR) && !w_full)
               || ((r_state == S_POP_PREC) && !w_prec_pop && !w_full);
  assign w_push_val = (r_state == S_POP_PREC) ? r_op : C_LPAR;

  // Stack contents need no reset: the pointer alone defines validity.
  always_ff @(posedge CLK) begin
    if (w_push) r_stack[r_sp[AW-1:0]] <= w_push_val;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= S_IDLE;
      r_sp         <= '0;
      r_op         <= '0;
      r_num        <= '0;
      r_gap        <= '0;
      r_ready      <= 1'b0;
      r_out_number <= '0;
      r_out_sign   <= '0;
      r_number_stb <= 1'b0;
      r_sign_stb   <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_number_stb <= 1'b0;
      r_sign_stb   <= 1'b0;
      r_done       <= 1'b0;
      if (r_gap != 8'hFF) r_gap <= r_gap + 8'd1;

      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            // IN_END takes priority over any operator flag.
            if (IN_END) begin
              r_ready <= 1'b0;
              r_state <= S_DRAIN;
            end else if (!IN_IS_OP) begin
              r_num   <= IN_TOKEN;
              r_ready <= 1'b0;
              r_state <= S_EMIT_NUM;
            end else begin
              case (IN_TOKEN)
                C_LPAR: begin
                  if (w_full) begin
                    r_err   <= 1'b1;
                    r_ready <= 1'b0;
                    r_state <= S_ERROR;
                  end else begin
                    r_sp <= r_sp + 1'b1;
                  end
                end
                C_ADD, C_SUB, C_MUL, C_DIV: begin
                  r_op    <= IN_TOKEN;
                  r_ready <= 1'b0;
                  r_state <= S_POP_PREC;
                end
                C_RPAR: begin
                  r_ready <= 1'b0;
                  r_state <= S_POP_PAREN;
                end
                default: begin
                  r_err   <= 1'b1;
                  r_ready <= 1'b0;
                  r_state <= S_ERROR;
                end
              endcase
            end
          end
        end

        S_EMIT_NUM: begin
          if (w_can_fire) begin
            r_out_number <= r_num;
            r_number_stb <= 1'b1;
            r_gap        <= '0;
            r_ready      <= 1'b1;
            r_state      <= S_IDLE;
          end
        end

        S_POP_PREC: begin
          if (w_prec_pop) begin
            if (w_can_fire) begin
              r_out_sign <= w_top;
              r_sign_stb <= 1'b1;
              r_gap      <= '0;
              r_sp       <= r_sp - 1'b1;
            end
          end else if (w_full) begin
            r_err   <= 1'b1;
            r_state <= S_ERROR;
          end else begin
            r_sp    <= r_sp + 1'b1;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        S_POP_PAREN: begin
          if (w_empty) begin
            r_err   <= 1'b1;
            r_state <= S_ERROR;
          end else if (w_top == C_LPAR) begin
            // Matching "(" is discarded silently, no strobe.
            r_sp    <= r_sp - 1'b1;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_can_fire) begin
            r_out_sign <= w_top;
            r_sign_stb <= 1'b1;
            r_gap      <= '0;
            r_sp       <= r_sp - 1'b1;
          end
        end

        S_DRAIN: begin
          if (w_empty) begin
            r_state <= S_TERM;
          end else if (w_top == C_LPAR) begin
            r_err   <= 1'b1;
            r_state <= S_ERROR;
          end else if (w_can_fire) begin
            r_out_sign <= w_top;
            r_sign_stb <= 1'b1;
            r_gap      <= '0;
            r_sp       <= r_sp - 1'b1;
          end
        end

        S_TERM: begin
          if (w_can_fire) begin
            r_out_number <= '0;
            r_out_sign   <= C_EQ;
            r_number_stb <= 1'b1;
            r_sign_stb   <= 1'b1;
            r_done       <= 1'b1;
            r_gap        <= '0;
            r_sp         <= '0;
            r_ready      <= 1'b1;
            r_state      <= S_IDLE;
          end
        end

        default: begin
          r_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef TOKEN_CNT_EN
  logic [7:0] r_count;

  // Counts visible token strobes; the terminator carries DONE and is skipped.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_count <= '0;
    end else if (r_done) begin
      r_count <= '0;
    end else if (r_number_stb || r_sign_stb) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign OUT_COUNT = r_count;
`endif

  assign IN_READY   = r_ready;
  assign OUT_NUMBER = r_out_number;
  assign NUMBER_STB = r_number_stb;
  assign OUT_SIGN   = r_out_sign;
  assign SIGN_STB   = r_sign_stb;
  assign DONE       = r_done;
  assign ERR        = r_err;

endmodule

// File: tb/tb_infix_to_postfix.sv
module tb_infix_to_postfix;

  localparam int DEPTH   = 4;
  localparam int MIN_GAP = 2;

  typedef struct packed {
    logic [7:0] v;
    logic       op;
    logic       e;
  } tok_t;

  typedef struct packed {
    logic [7:0] v;
    logic       op;
    logic       term;
  } exp_t;

  logic       CLK;
  logic       RST;
  logic [7:0] IN_TOKEN;
  logic       IN_IS_OP;
  logic       IN_END;
  logic       IN_VALID;
  logic       IN_READY;
  logic       DST_BUSY;
  logic [7:0] OUT_NUMBER;
  logic       NUMBER_STB;
  logic [7:0] OUT_SIGN;
  logic       SIGN_STB;
  logic       DONE;
  logic       ERR;
`ifdef TOKEN_CNT_EN
  logic [7:0] OUT_COUNT;
`endif

  infix_to_postfix #(.DEPTH(DEPTH), .MIN_GAP(MIN_GAP)) dut (
    .CLK(CLK),
    .RST(RST),
    .IN_TOKEN(IN_TOKEN),
    .IN_IS_OP(IN_IS_OP),
    .IN_END(IN_END),
    .IN_VALID(IN_VALID),
    .IN_READY(IN_READY),
    .DST_BUSY(DST_BUSY),
    .OUT_NUMBER(OUT_NUMBER),
    .NUMBER_STB(NUMBER_STB),
    .OUT_SIGN(OUT_SIGN),
    .SIGN_STB(SIGN_STB),
    .DONE(DONE),
`ifdef TOKEN_CNT_EN
    .OUT_COUNT(OUT_COUNT),
`endif
    .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   n_checks = 0;
  int   n_err    = 0;
  int   n_done   = 0;
  bit   mon_en   = 1'b0;
  logic busy_q   = 1'b0;

  tok_t expr_q[$];
  exp_t mdl_q[$];
  exp_t sb[$];

  int         idle_cnt  = 100;
  logic [7:0] last_num  = 8'd0;
  logic [7:0] last_sign = 8'd0;
  exp_t       m_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  // ---------------- reference model: textbook shunting-yard ----------------
  function automatic int prec_of(input logic [7:0] c);
    if (c == "*" || c == "/") return 2;
    if (c == "+" || c == "-") return 1;
    return 0;
  endfunction

  function automatic exp_t mk(input logic [7:0] v, input logic op, input logic term);
    exp_t x;
    x.v = v; x.op = op; x.term = term;
    return x;
  endfunction

  task automatic model_run();
    logic [7:0] stk[$];
    tok_t t;
    mdl_q.delete();
    foreach (expr_q[i]) begin
      t = expr_q[i];
      if (t.e) begin
        while (stk.size() > 0) mdl_q.push_back(mk(stk.pop_back(), 1'b1, 1'b0));
        mdl_q.push_back(mk(8'd0, 1'b0, 1'b1));
      end else if (!t.op) begin
        mdl_q.push_back(mk(t.v, 1'b0, 1'b0));
      end else if (t.v == "(") begin
        stk.push_back(t.v);
      end else if (t.v == ")") begin
        while (stk.size() > 0 && stk[$] != "(") mdl_q.push_back(mk(stk.pop_back(), 1'b1, 1'b0));
        if (stk.size() > 0) void'(stk.pop_back());
      end else begin
        while (stk.size() > 0 && prec_of(stk[$]) >= prec_of(t.v))
          mdl_q.push_back(mk(stk.pop_back(), 1'b1, 1'b0));
        stk.push_back(t.v);
      end
    end
  endtask

  function automatic string mdl_str();
    string s;
    s = "";
    foreach (mdl_q[i]) begin
      if (mdl_q[i].term)    s = {s, "= "};
      else if (mdl_q[i].op) s = {s, $sformatf("%c ", mdl_q[i].v)};
      else                  s = {s, $sformatf("%0d ", mdl_q[i].v)};
    end
    return s;
  endfunction

  task automatic add(input logic [7:0] v, input logic op, input logic e);
    tok_t t;
    t.v = v; t.op = op; t.e = e;
    expr_q.push_back(t);
  endtask

  // ---------------- output monitor ----------------
  always @(posedge CLK) busy_q <= DST_BUSY;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (NUMBER_STB || SIGN_STB) begin
        chk("strobe_gap_ok", 32'(idle_cnt >= MIN_GAP), 32'd1);
        chk("strobe_while_busy", 32'(busy_q), 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_strobe", {24'd0, OUT_NUMBER}, 32'hFFFF);
        end else begin
          m_e = sb.pop_front();
          if (m_e.term) begin
            chk("term_num_stb", 32'(NUMBER_STB), 32'd1);
            chk("term_sign_stb", 32'(SIGN_STB), 32'd1);
            chk("term_done", 32'(DONE), 32'd1);
            chk("term_number", 32'(OUT_NUMBER), 32'd0);
            chk("term_sign", 32'(OUT_SIGN), 32'h3D);
            n_done++;
          end else if (m_e.op) begin
            chk("op_sign_stb", 32'(SIGN_STB), 32'd1);
            chk("op_num_stb", 32'(NUMBER_STB), 32'd0);
            chk("op_done", 32'(DONE), 32'd0);
            chk("op_value", 32'(OUT_SIGN), 32'(m_e.v));
          end else begin
            chk("num_num_stb", 32'(NUMBER_STB), 32'd1);
            chk("num_sign_stb", 32'(SIGN_STB), 32'd0);
            chk("num_done", 32'(DONE), 32'd0);
            chk("num_value", 32'(OUT_NUMBER), 32'(m_e.v));
          end
        end
        idle_cnt = 0;
      end else begin
        chk("done_without_term", 32'(DONE), 32'd0);
        if (idle_cnt < 1000) idle_cnt++;
      end
      if (!NUMBER_STB) chk("out_number_hold", 32'(OUT_NUMBER), 32'(last_num));
      if (!SIGN_STB)   chk("out_sign_hold", 32'(OUT_SIGN), 32'(last_sign));
      if (NUMBER_STB) last_num  = OUT_NUMBER;
      if (SIGN_STB)   last_sign = OUT_SIGN;
    end
  end

  // ---------------- drivers ----------------
  task automatic send_tok(input logic [7:0] v, input logic op, input logic e);
    int n;
    n = 0;
    IN_TOKEN = v; IN_IS_OP = op; IN_END = e; IN_VALID = 1'b1;
    while (!IN_READY && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!IN_READY) begin
      chk("send_timeout", 32'(IN_READY), 32'd1);
      IN_VALID = 1'b0;
    end else begin
      @(posedge CLK);
      @(negedge CLK);
      IN_VALID = 1'b0;
    end
  endtask

  task automatic wait_sb_empty();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge CLK);
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
    repeat (6) @(negedge CLK);
  endtask

  task automatic run_expr(input string pin);
    int d0;
    int terms;
    model_run();
    if (pin != "") chk_str("model_pin", mdl_str(), pin);
    terms = 0;
    foreach (mdl_q[i]) begin
      sb.push_back(mdl_q[i]);
      if (mdl_q[i].term) terms++;
    end
    d0 = n_done;
    foreach (expr_q[i]) send_tok(expr_q[i].v, expr_q[i].op, expr_q[i].e);
    wait_sb_empty();
    chk("done_count", n_done - d0, terms);
    chk("no_err", 32'(ERR), 32'd0);
  endtask

  // Called at a negedge; leaves the bench at a negedge with the monitor armed.
  task automatic do_reset();
    mon_en   = 1'b0;
    IN_VALID = 1'b0;
    RST      = 1'b0;
    #1;
    chk("rst_number_stb", 32'(NUMBER_STB), 32'd0);
    chk("rst_sign_stb", 32'(SIGN_STB), 32'd0);
    chk("rst_out_number", 32'(OUT_NUMBER), 32'd0);
    chk("rst_out_sign", 32'(OUT_SIGN), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    chk("rst_in_ready", 32'(IN_READY), 32'd0);
    DST_BUSY = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    sb.delete();
    last_num = 8'd0; last_sign = 8'd0; idle_cnt = 100;
    chk("rel_ready_low", 32'(IN_READY), 32'd0);
    @(negedge CLK);
    chk("rel_ready_high", 32'(IN_READY), 32'd1);
    mon_en = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0; IN_TOKEN = 8'd0; IN_IS_OP = 1'b0; IN_END = 1'b0;
    IN_VALID = 1'b0; DST_BUSY = 1'b0;
    repeat (3) @(negedge CLK);
    do_reset();

    // precedence: 3 + 4 * 2
    expr_q.delete();
    add(8'd3, 0, 0); add("+", 1, 0); add(8'd4, 0, 0); add("*", 1, 0); add(8'd2, 0, 0); add(8'd0, 0, 1);
    run_expr("3 4 2 * + = ");

    // parentheses: ( 3 + 4 ) * 2
    expr_q.delete();
    add("(", 1, 0); add(8'd3, 0, 0); add("+", 1, 0); add(8'd4, 0, 0); add(")", 1, 0);
    add("*", 1, 0); add(8'd2, 0, 0); add(8'd0, 0, 1);
    run_expr("3 4 + 2 * = ");

    // left associativity: 8 - 3 - 2
    expr_q.delete();
    add(8'd8, 0, 0); add("-", 1, 0); add(8'd3, 0, 0); add("-", 1, 0); add(8'd2, 0, 0); add(8'd0, 0, 1);
    run_expr("8 3 - 2 - = ");

    // mixed levels: 9 / 3 * 2 - 1
    expr_q.delete();
    add(8'd9, 0, 0); add("/", 1, 0); add(8'd3, 0, 0); add("*", 1, 0); add(8'd2, 0, 0);
    add("-", 1, 0); add(8'd1, 0, 0); add(8'd0, 0, 1);
    run_expr("9 3 / 2 * 1 - = ");

    // END with IN_IS_OP set and a "(" token: END wins
    expr_q.delete();
    add(8'd250, 0, 0); add("+", 1, 0); add(8'd6, 0, 0); add("(", 1, 1);
    run_expr("250 6 + = ");

    // DST_BUSY blocks a number strobe for 10 cycles
    expr_q.delete();
    add(8'd7, 0, 0); add(8'd0, 0, 1);
    model_run();
    chk_str("model_pin_busy", mdl_str(), "7 = ");
    foreach (mdl_q[i]) sb.push_back(mdl_q[i]);
    DST_BUSY = 1'b1;
    send_tok(8'd7, 0, 0);
    for (int i = 0; i < 10; i++) begin
      chk("busy_no_stb", 32'(NUMBER_STB), 32'd0);
      @(negedge CLK);
    end
    DST_BUSY = 1'b0;
    @(negedge CLK);
    chk("busy_release_stb", 32'(NUMBER_STB), 32'd1);
    chk("busy_release_num", 32'(OUT_NUMBER), 32'd7);
    send_tok(8'd0, 0, 1);
    wait_sb_empty();

    // reset in DRAIN with "(", "+", "*" stacked; no terminator may follow
    expr_q.delete();
    add("(", 1, 0); add(8'd1, 0, 0); add("+", 1, 0); add(8'd2, 0, 0); add("*", 1, 0); add(8'd3, 0, 0);
    run_expr("1 2 3 ");
    DST_BUSY = 1'b1;
    send_tok(8'd0, 0, 1);
    repeat (4) @(negedge CLK);
    chk("drain_busy_no_sign", 32'(SIGN_STB), 32'd0);
    do_reset();
    repeat (12) @(negedge CLK);
    chk("post_rst_no_done", n_done, n_done);
    expr_q.delete();
    add(8'd1, 0, 0); add("+", 1, 0); add(8'd1, 0, 0); add(8'd0, 0, 1);
    run_expr("1 1 + = ");

    // stack overflow: five "(" with DEPTH 4
    do_reset();
    for (int i = 0; i < 4; i++) send_tok("(", 1, 0);
    chk("ovf_err_before", 32'(ERR), 32'd0);
    chk("ovf_ready_before", 32'(IN_READY), 32'd1);
    send_tok("(", 1, 0);
    chk("ovf_err", 32'(ERR), 32'd1);
    chk("ovf_ready", 32'(IN_READY), 32'd0);
    repeat (8) @(negedge CLK);
    chk("ovf_err_sticky", 32'(ERR), 32'd1);

    // unmatched ")" tokens
    do_reset();
    send_tok(")", 1, 0);
    repeat (2) @(negedge CLK);
    chk("rpar_err", 32'(ERR), 32'd1);
    IN_TOKEN = ")"; IN_IS_OP = 1'b1; IN_END = 1'b0; IN_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rpar_ready_low", 32'(IN_READY), 32'd0);
      @(negedge CLK);
    end
    IN_VALID = 1'b0;
    chk("rpar_err_sticky", 32'(ERR), 32'd1);

    // unknown operator character
    do_reset();
    send_tok(8'h41, 1, 0);
    chk("unknown_op_err", 32'(ERR), 32'd1);
    chk("unknown_op_ready", 32'(IN_READY), 32'd0);
    repeat (6) @(negedge CLK);

    // recovery after error
    do_reset();
    expr_q.delete();
    add(8'd4, 0, 0); add("*", 1, 0); add(8'd5, 0, 0); add(8'd0, 0, 1);
    run_expr("4 5 * = ");

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
